bcd_time_counter: RTL and testbench

Parametrised BCD stopwatch/timer core: a prescaled tick drives a chained BCD time register (fractional seconds, seconds, minutes, hours) that counts up or down, with preset load, lap capture, overflow and countdown-done flags. Sits between the button/control FSM and the seven-segment display mux. All digits update atomically on the tick edge; there is no ripple delay between digits.

---
 rtl/bcd_time_counter_if.sv | 22 ++
 rtl/bcd_time_counter.sv | 96 +++++++++
 tb/tb_bcd_time_counter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_time_counter_if.sv
// bcd_time_counter_if: control and time bus between the stopwatch control FSM, the counter core and the display mux.
interface bcd_time_counter_if #(parameter int W = 32);
  logic enCounterIn;
  logic clrCounterIn;
  logic modeDownIn;
  logic loadIn;
  logic [W-1:0] loadBcdIn;
  logic lapIn;
  logic [W-1:0] timeBcdOut;
  logic [W-1:0] lapBcdOut;
  logic lapValidOut;
  logic overflowOut;
  logic doneOut;
  modport master(
    output enCounterIn, clrCounterIn, modeDownIn, loadIn, loadBcdIn, lapIn,
    input timeBcdOut, lapBcdOut, lapValidOut, overflowOut, doneOut
  );
  modport slave(
    input enCounterIn, clrCounterIn, modeDownIn, loadIn, loadBcdIn, lapIn,
    output timeBcdOut, lapBcdOut, lapValidOut, overflowOut, doneOut
  );
endinterface

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: prescaled up/down BCD stopwatch core with preset load, lap capture (STOPWATCH_LAP_EN) and wrap/done pulses.
module bcd_time_counter #(
  parameter int CLK_HZ = 100000000,
  parameter int FRAC_DIGITS = 3,
  parameter int HOUR_DIGITS = 1
)(
  input logic clkIn,
  input logic rstNIn,
  bcd_time_counter_if.slave bus
);
  localparam int NUM_DIGITS = FRAC_DIGITS + 4 + HOUR_DIGITS;
  localparam int W = 4 * NUM_DIGITS;
  localparam int DIV = CLK_HZ / (10 ** FRAC_DIGITS);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int HO = FRAC_DIGITS + 4;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  function automatic logic [3:0] digitMax(int i);
    int r = i - FRAC_DIGITS;
    return (r == 1 || r == 3) ? 4'd5 : (r == 5) ? 4'd2 : 4'd9;
  endfunction
  logic [PW-1:0] pre;
  logic [W-1:0] timeBcd, incBcd, decBcd, loadSan;
  logic [3:0] d, lim, ld, limL, hourTens, loadTens;
  logic carry, borrow, tick, isZero, overflow, done;
  assign tick = bus.enCounterIn && pre == LAST;
  assign isZero = timeBcd == '0;
  // Hours are capped at 23 when two digits exist, so the ones limit depends on the tens digit.
  assign hourTens = HOUR_DIGITS == 2 ? timeBcd[W-1 -: 4] : 4'd0;
  assign loadTens = HOUR_DIGITS == 2 ? (bus.loadBcdIn[W-1 -: 4] > 4'd2 ? 4'd2 : bus.loadBcdIn[W-1 -: 4]) : 4'd0;
  always_comb begin
    incBcd = timeBcd;
    decBcd = timeBcd;
    loadSan = bus.loadBcdIn;
    carry = 1'b1;
    borrow = 1'b1;
    d = '0;
    lim = '0;
    ld = '0;
    limL = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = timeBcd[4*i +: 4];
      lim = (HOUR_DIGITS == 2 && i == HO && hourTens == 4'd2) ? 4'd3 : digitMax(i);
      incBcd[4*i +: 4] = !carry ? d : (d == lim) ? 4'd0 : d + 4'd1;
      carry = carry && d == lim;
      decBcd[4*i +: 4] = !borrow ? d : (d == 4'd0) ? digitMax(i) : d - 4'd1;
      borrow = borrow && d == 4'd0;
      ld = bus.loadBcdIn[4*i +: 4];
      limL = (HOUR_DIGITS == 2 && i == HO && loadTens == 4'd2) ? 4'd3 : digitMax(i);
      loadSan[4*i +: 4] = ld > limL ? limL : ld;
    end
  end
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      pre <= '0;
      timeBcd <= '0;
      overflow <= 1'b0;
      done <= 1'b0;
    end else if (bus.clrCounterIn) begin
      pre <= '0;
      timeBcd <= '0;
      overflow <= 1'b0;
      done <= 1'b0;
    end else begin
      pre <= (bus.loadIn || tick) ? '0 : bus.enCounterIn ? pre + 1'b1 : pre;
      timeBcd <= bus.loadIn ? loadSan : !tick ? timeBcd : !bus.modeDownIn ? incBcd : isZero ? timeBcd : decBcd;
      overflow <= !bus.loadIn && tick && !bus.modeDownIn && carry;
      done <= !bus.loadIn && tick && bus.modeDownIn && !isZero && decBcd == '0;
    end
  end
  assign bus.timeBcdOut = timeBcd;
  assign bus.overflowOut = overflow;
  assign bus.doneOut = done;
`ifdef STOPWATCH_LAP_EN
  logic [W-1:0] lap;
  logic lapValid;
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      lap <= '0;
      lapValid <= 1'b0;
    end else if (bus.clrCounterIn) begin
      lap <= '0;
      lapValid <= 1'b0;
    end else if (bus.lapIn) begin
      lap <= timeBcd;
      lapValid <= 1'b1;
    end
  end
  assign bus.lapBcdOut = lap;
  assign bus.lapValidOut = lapValid;
`else
  logic unusedLap;
  assign unusedLap = bus.lapIn;
  assign bus.lapBcdOut = '0;
  assign bus.lapValidOut = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter: directed plus randomized checks of bcd_time_counter against an integer tenths-of-a-second model.
module tb_bcd_time_counter;
  localparam int CLK_HZ = 1000;
  localparam int FRAC = 1;
  localparam int HOURS = 1;
  localparam int W = 24;
  localparam int DIV = 100;
  localparam int MAXV = 359999;
  logic clkIn = 1'b0;
  logic rstNIn = 1'b0;
  bcd_time_counter_if #(.W(W)) bus();
  bcd_time_counter #(.CLK_HZ(CLK_HZ), .FRAC_DIGITS(FRAC), .HOUR_DIGITS(HOURS)) dut(
    .clkIn(clkIn),
    .rstNIn(rstNIn),
    .bus(bus)
  );
  always #5 clkIn = ~clkIn;
  int tests = 0;
  int fails = 0;
  int mPre = 0;
  int mTime = 0;
  int mLap = 0;
  logic mLapValid = 1'b0;
  logic mOv = 1'b0;
  logic mDone = 1'b0;
  function automatic int cl(int x, int lim);
    return x > lim ? lim : x;
  endfunction
  function automatic logic [W-1:0] toBcd(int v);
    int s = (v / 10) % 60;
    int m = (v / 600) % 60;
    int h = v / 36000;
    return {4'(h), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(v % 10)};
  endfunction
  function automatic int fromBcd(logic [W-1:0] b);
    int fr = cl(int'(b[3:0]), 9);
    int so = cl(int'(b[7:4]), 9);
    int st = cl(int'(b[11:8]), 5);
    int mo = cl(int'(b[15:12]), 9);
    int mt = cl(int'(b[19:16]), 5);
    int h = cl(int'(b[23:20]), 9);
    return fr + 10 * (so + 10 * st) + 600 * (mo + 10 * mt) + 36000 * h;
  endfunction
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic checkAll();
    chk("time", bus.timeBcdOut, toBcd(mTime));
    chk("overflow", W'(bus.overflowOut), W'(mOv));
    chk("done", W'(bus.doneOut), W'(mDone));
    chk("lap", bus.lapBcdOut, toBcd(mLap));
    chk("lapValid", W'(bus.lapValidOut), W'(mLapValid));
  endtask
  task automatic modelReset();
    mPre = 0;
    mTime = 0;
    mLap = 0;
    mLapValid = 1'b0;
    mOv = 1'b0;
    mDone = 1'b0;
  endtask
  task automatic modelEdge();
    if (bus.clrCounterIn) modelReset();
    else begin
`ifdef STOPWATCH_LAP_EN
      if (bus.lapIn) begin
        mLap = mTime;
        mLapValid = 1'b1;
      end
`endif
      mOv = 1'b0;
      mDone = 1'b0;
      if (bus.loadIn) begin
        mTime = fromBcd(bus.loadBcdIn);
        mPre = 0;
      end else if (bus.enCounterIn) begin
        if (mPre == DIV - 1) begin
          mPre = 0;
          if (!bus.modeDownIn) begin
            mOv = mTime == MAXV;
            mTime = (mTime + 1) % (MAXV + 1);
          end else if (mTime != 0) begin
            mTime--;
            mDone = mTime == 0;
          end
        end else mPre++;
      end
    end
  endtask
  task automatic step();
    @(posedge clkIn);
    modelEdge();
    #1 checkAll();
    @(negedge clkIn);
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  // ctl = {en, clr, down, load, lap}
  task automatic drive(input logic [4:0] ctl, input logic [W-1:0] lb);
    {bus.enCounterIn, bus.clrCounterIn, bus.modeDownIn, bus.loadIn, bus.lapIn} = ctl;
    bus.loadBcdIn = lb;
  endtask
  initial begin
    logic [W-1:0] lb;
    drive(5'b00000, '0);
    modelReset();
    #12 checkAll();
    @(negedge clkIn) rstNIn = 1'b1;
    drive(5'b10000, '0);
    run(1000);
    chk("run1000", bus.timeBcdOut, 24'h000010);
    drive(5'b10010, 24'h959599);
    step();
    drive(5'b10000, '0);
    run(99);
    step();
    chk("wrap_time", bus.timeBcdOut, '0);
    chk("wrap_ov", W'(bus.overflowOut), W'(1'b1));
    step();
    chk("ov_once", W'(bus.overflowOut), W'(1'b0));
    drive(5'b10110, 24'h000002);
    step();
    drive(5'b10100, '0);
    run(100);
    chk("down_1", bus.timeBcdOut, 24'h000001);
    run(100);
    chk("down_0", bus.timeBcdOut, '0);
    chk("done_hi", W'(bus.doneOut), W'(1'b1));
    step();
    run(99);
    chk("hold_0", bus.timeBcdOut, '0);
    chk("done_once", W'(bus.doneOut), W'(1'b0));
    drive(5'b10010, 24'h0007C0);
    step();
    chk("sanitize", bus.timeBcdOut, 24'h000590);
    drive(5'b10010, 24'h000019);
    step();
    drive(5'b10000, '0);
    run(99);
    drive(5'b10001, '0);
    step();
    drive(5'b10000, '0);
    chk("lap_time", bus.timeBcdOut, 24'h000020);
`ifdef STOPWATCH_LAP_EN
    chk("lap_val", bus.lapBcdOut, 24'h000019);
    chk("lap_valid", W'(bus.lapValidOut), W'(1'b1));
`else
    chk("lap_off", bus.lapBcdOut, '0);
    chk("lap_valid_off", W'(bus.lapValidOut), W'(1'b0));
`endif
    run(99);
    drive(5'b00000, '0);
    run(5);
    chk("en_hold", bus.timeBcdOut, 24'h000020);
    drive(5'b10000, '0);
    step();
    chk("en_resume", bus.timeBcdOut, 24'h000021);
    run(37);
    #3 rstNIn = 1'b0;
    #1 chk("arst_time", bus.timeBcdOut, '0);
    chk("arst_lap", bus.lapBcdOut, '0);
    chk("arst_flags", W'({bus.lapValidOut, bus.overflowOut, bus.doneOut}), '0);
    modelReset();
    @(negedge clkIn) rstNIn = 1'b1;
    run(150);
    drive(5'b11011, 24'h123456);
    step();
    chk("clr_load", bus.timeBcdOut, '0);
    chk("clr_lap", bus.lapBcdOut, '0);
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(2))
        0: lb = toBcd(MAXV - int'($urandom_range(2)));
        1: lb = toBcd(int'($urandom_range(2)));
        default: lb = W'($urandom);
      endcase
      drive({1'($urandom % 16 != 0), 1'($urandom % 300 == 0), 1'($urandom % 2), 1'($urandom % 150 == 0), 1'($urandom % 60 == 0)}, lb);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
